hatch_fetch_arbiter: RTL
========================

Name: hatch_fetch_arbiter

Overview:
- Shares the single 48-bit-wide hatch instruction memory between two requesters: port 0 is CPU instruction fetch, port 1 is debug/loader readback.
- Translates byte addresses to word indices (6 bytes per word) and rejects misaligned or out-of-range addresses with an error response.
- Drives the external memory's synchronous read port (1-cycle latency).
- Allows one outstanding transaction at a time, with round-robin arbitration and valid/ready handshakes on both sides.

Parameters:
- DEPTH, 256, number of 48-bit words in the instruction memory.
- IDXW, 8, width of the word index; must satisfy 2^IDXW >= DEPTH.
- DW, 48, instruction word width in bits (6 bytes).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 request valid.
- req0_addr  input  32  port 0 byte address.
- req0_ready  output  1  port 0 request accepted this cycle.
- rsp0_valid  output  1  port 0 response valid.
- rsp0_data  output  DW  port 0 instruction word.
- rsp0_err  output  1  port 0 address error (misaligned or out of range).
- rsp0_ready  input  1  port 0 consumer ready.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err, rsp1_ready: identical to the port 0 signals, for port 1.
- mem_en  output  1  memory read enable.
- mem_index  output  IDXW  memory word index.
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: all outputs 0. State = IDLE. last_grant = 1, so port 0 wins the first contention.
- States:
  - IDLE: accepts requests.
  - READ: mem_en = 1, mem_index = the registered index.
  - RESP: response held.
- Ready: reqN_ready is combinational. It is 1 only in IDLE, and only for the granted port, when that port's valid is high. Never both readies at once.
- Arbitration:
  - One valid: grant it.
  - Both valid: grant the port that is not last_grant.
  - last_grant updates on every accept.
- Address check, done on the accepted address:
  - idx = addr / 6, rem = addr % 6, exact for all 32-bit values.
  - Constant-division implementation is free, but must be combinational within one cycle.
  - err = (rem != 0) or (idx >= DEPTH).
- Normal path (err = 0):
  - Accept in cycle N.
  - READ in cycle N+1: mem_en = 1, mem_index = idx[IDXW-1:0].
  - Cycle N+2: capture mem_rdata; rspN_valid = 1, rspN_err = 0.
  - Minimum latency: accept to response valid = 2 cycles.
- Error path (err = 1):
  - Accept in cycle N.
  - Cycle N+1: RESP with rspN_valid = 1, rspN_err = 1, rspN_data = 0.
  - No memory access (mem_en stays 0).
- RESP:
  - Response only on the port that was granted. The other port's rsp_valid stays 0.
  - data/err are held stable while valid && !ready.
  - Handshake completes when rspN_valid && rspN_ready. The next cycle returns to IDLE with rsp_valid = 0.
  - No new accept occurs in the handshake cycle. Maximum throughput is therefore 1 transaction per 3 cycles (normal path) or 2 cycles (error path).
- Idle outputs: mem_en = 0 outside READ. mem_index holds its last value (don't-care when mem_en = 0).
- Request side: a requester holding valid with a stable address while not granted must not be dropped. The arbiter never consumes an address without asserting ready.
- Address changes: a requester changing its address while not ready is legal. The address sampled is the one present in the accept cycle.
- Response data: responses carry only the captured word. mem_rdata is sampled exactly one cycle after mem_en and ignored otherwise.
- Reset mid-operation:
  - Asserting rst in any state aborts immediately (asynchronously) to IDLE with all outputs 0.
  - Any in-flight transaction is discarded with no response.
  - After rst deasserts, the first accept occurs no earlier than the first rising edge with rst low.
- Address 0 is legal (idx 0).
- Last legal word: byte address 6*(DEPTH-1) = 1530 (default).
- Address 1536 (idx 256) is out of range → err.
- Address 0xFFFFFFFE (idx 715827882, rem 2) → err.

Test Plan:
- Reset, then req0 addr 12 alone → req0_ready in accept cycle; mem_en with mem_index = 2 one cycle later; rsp0_valid with rsp0_data = mem[2], err = 0 two cycles after accept; rsp1_valid stays 0.
- req0 and req1 valid together (addr 0 and 6), both holding valid, rsp_ready tied 1 → port 0 granted first, then port 1; third contention grants port 0 again; responses return mem[0], then mem[1].
- req1 addr 7 (misaligned), then addr 1536 (out of range) → each returns rsp1_err = 1, data = 0, one cycle after accept; mem_en never asserted; addr 1530 → mem_index = 255, err = 0.
- rsp0_ready held 0 for 5 cycles after rsp0_valid → rsp0_valid, data, err stable; req1_ready stays 0 throughout; on the ready cycle the handshake completes; IDLE next cycle; req1 accepted that cycle.
- rst asserted mid-cycle during READ → all outputs 0 immediately, no response issued; after release, a fresh req0 addr 18 yields mem[3] with normal 2-cycle latency.
- Randomised addresses on both ports vs. reference model (addr/6, addr%6, DEPTH check) → every accepted request gets exactly one response on the correct port with the correct data/err, in order, with no starvation over 10k cycles.

Source files
------------

// File: rtl/hatch_fetch_arbiter.sv
// rtl/hatch_fetch_arbiter.sv - two-port round-robin fetch arbiter for the 48-bit hatch instruction memory
// One transaction in flight; byte addresses are mapped to 6-byte word indices and range/alignment checked.
module hatch_fetch_arbiter #(
  parameter int DEPTH = 256,
  parameter int IDXW  = 8,
  parameter int DW    = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [31:0]     req0_addr,
  output logic            req0_ready,
  output logic            rsp0_valid,
  output logic [DW-1:0]   rsp0_data,
  output logic            rsp0_err,
  input  logic            rsp0_ready,
  input  logic            req1_valid,
  input  logic [31:0]     req1_addr,
  output logic            req1_ready,
  output logic            rsp1_valid,
  output logic [DW-1:0]   rsp1_data,
  output logic            rsp1_err,
  input  logic            rsp1_ready,
  output logic            mem_en,
  output logic [IDXW-1:0] mem_index,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          cur_port;
  logic          fresh;
  logic [DW-1:0] data_q;

  logic          grant;
  logic          accept;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_idx;
  logic [31:0]   acc_rem;
  logic          acc_err;
  logic [DW-1:0] word;
  logic          rsp_done;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  // Gated by rst so nothing can be accepted while reset is still asserted.
  assign accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign acc_addr = grant ? req1_addr : req0_addr;
  assign acc_idx  = acc_addr / 32'd6;
  assign acc_rem  = acc_addr - acc_idx * 32'd6;
  assign acc_err  = (acc_rem != 32'd0) || (acc_idx >= 32'(DEPTH));

  // The first RESP cycle forwards the memory word directly, giving 2-cycle latency; later cycles replay the capture.
  assign word      = fresh ? mem_rdata : data_q;
  assign rsp0_data = rsp0_valid ? word : '0;
  assign rsp1_data = rsp1_valid ? word : '0;
  assign rsp_done  = cur_port ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      fresh      <= 1'b0;
      data_q     <= '0;
      mem_en     <= 1'b0;
      mem_index  <= '0;
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            cur_port   <= grant;
            if (acc_err) begin
              state      <= RESP;
              data_q     <= '0;
              rsp0_valid <= !grant;
              rsp0_err   <= !grant;
              rsp1_valid <= grant;
              rsp1_err   <= grant;
            end else begin
              state     <= READ;
              mem_en    <= 1'b1;
              mem_index <= acc_idx[IDXW-1:0];
            end
          end
        end
        READ: begin
          state      <= RESP;
          mem_en     <= 1'b0;
          fresh      <= 1'b1;
          rsp0_valid <= !cur_port;
          rsp1_valid <= cur_port;
          rsp0_err   <= 1'b0;
          rsp1_err   <= 1'b0;
        end
        RESP: begin
          fresh <= 1'b0;
          if (fresh) data_q <= mem_rdata;
          if (rsp_done) begin
            state      <= IDLE;
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
